// File: rtl/rv32v_memory_stage.sv
// Vector memory stage: runs up to two element accesses one after another over a
// single 32-bit data port, then presents one registered writeback bundle.
module rv32v_memory_stage #(
  parameter int OFFSET_W = 7
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                load,
  input  logic                store,
  input  logic                wen0,
  input  logic                wen1,
  input  logic [31:0]         aluresult0,
  input  logic [31:0]         aluresult1,
  input  logic [31:0]         storedata0,
  input  logic [31:0]         storedata1,
  input  logic [OFFSET_W-1:0] woffset0,
  input  logic [OFFSET_W-1:0] woffset1,
  input  logic [1:0]          eew,
  input  logic [4:0]          vd,
  input  logic                config_type,
  input  logic                single_bit_write,
  input  logic [7:0]          vtype,
  input  logic [31:0]         vl,
  input  logic [31:0]         vstart,
  output logic                dren,
  output logic                dwen,
  output logic [31:0]         daddr,
  output logic [31:0]         dstore,
  output logic [3:0]          dbyte_en,
  input  logic                dbusy,
  input  logic [31:0]         dload,
  output logic                out_valid,
  output logic                out_wen0,
  output logic                out_wen1,
  output logic [31:0]         out_wdata0,
  output logic [31:0]         out_wdata1,
  output logic [OFFSET_W-1:0] out_woffset0,
  output logic [OFFSET_W-1:0] out_woffset1,
  output logic [4:0]          out_vd,
  output logic                out_config_type,
  output logic                out_single_bit_write,
  output logic [7:0]          out_vtype,
  output logic [31:0]         out_vl,
  output logic [31:0]         out_vstart,
  output logic                misaligned
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                load_q, load_d, store_q, store_d;
  logic                wen0_q, wen0_d, wen1_q, wen1_d;
  logic [31:0]         wdata0_q, wdata0_d, wdata1_q, wdata1_d;
  logic [31:0]         addr0_q, addr0_d, addr1_q, addr1_d;
  logic [31:0]         sdata0_q, sdata0_d, sdata1_q, sdata1_d;
  logic [OFFSET_W-1:0] woff0_q, woff0_d, woff1_q, woff1_d;
  logic [1:0]          eew_q, eew_d;
  logic [4:0]          vd_q, vd_d;
  logic                cfg_q, cfg_d, sbw_q, sbw_d;
  logic [7:0]          vtype_q, vtype_d;
  logic [31:0]         vl_q, vl_d, vstart_q, vstart_d;
  logic                mis_q, mis_d, need1_q, need1_d;

  logic        accept, mem_op, al0, al1, need0, need1, in_acc;
  logic [31:0] cur_addr, cur_sdata, shifted, elem;

  function automatic logic is_aligned(input logic [1:0] w, input logic [1:0] a);
    case (w)
      2'd0:    is_aligned = 1'b1;
      2'd1:    is_aligned = ~a[0];
      default: is_aligned = (a == 2'b00);
    endcase
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == DONE);
  assign accept   = in_valid & in_ready;
  assign mem_op   = load | store;
  assign al0      = is_aligned(eew, aluresult0[1:0]);
  assign al1      = is_aligned(eew, aluresult1[1:0]);
  assign need0    = mem_op & wen0 & al0;
  assign need1    = mem_op & wen1 & al1;

  // Request side is a pure function of state and latched lane, so it cannot
  // move while dbusy holds the state in place.
  assign in_acc    = (state_q == ACC0) || (state_q == ACC1);
  assign cur_addr  = (state_q == ACC1) ? addr1_q : addr0_q;
  assign cur_sdata = (state_q == ACC1) ? sdata1_q : sdata0_q;
  assign dren      = in_acc & load_q;
  assign dwen      = in_acc & store_q;
  assign daddr     = in_acc ? {cur_addr[31:2], 2'b00} : 32'd0;

  always_comb begin
    dstore   = 32'd0;
    dbyte_en = 4'd0;
    if (in_acc) begin
      case (eew_q)
        2'd0: begin
          dstore   = {4{cur_sdata[7:0]}};
          dbyte_en = 4'b0001 << cur_addr[1:0];
        end
        2'd1: begin
          dstore   = {2{cur_sdata[15:0]}};
          dbyte_en = 4'b0011 << {cur_addr[1], 1'b0};
        end
        default: begin
          dstore   = cur_sdata;
          dbyte_en = 4'b1111;
        end
      endcase
    end
  end

  assign shifted = dload >> {cur_addr[1:0], 3'b000};
  always_comb begin
    case (eew_q)
      2'd0:    elem = {24'd0, shifted[7:0]};
      2'd1:    elem = {16'd0, shifted[15:0]};
      default: elem = dload;
    endcase
  end

  always_comb begin
    state_d = state_q;  load_d = load_q;    store_d = store_q;
    wen0_d = wen0_q;    wen1_d = wen1_q;    wdata0_d = wdata0_q;  wdata1_d = wdata1_q;
    addr0_d = addr0_q;  addr1_d = addr1_q;  sdata0_d = sdata0_q;  sdata1_d = sdata1_q;
    woff0_d = woff0_q;  woff1_d = woff1_q;  eew_d = eew_q;        vd_d = vd_q;
    cfg_d = cfg_q;      sbw_d = sbw_q;      vtype_d = vtype_q;    vl_d = vl_q;
    vstart_d = vstart_q; mis_d = mis_q;     need1_d = need1_q;
    case (state_q)
      ACC0: if (!dbusy) begin
        if (load_q) wdata0_d = elem;
        state_d = need1_q ? ACC1 : DONE;
      end
      ACC1: if (!dbusy) begin
        if (load_q) wdata1_d = elem;
        state_d = DONE;
      end
      default: begin
        if (accept) begin
          load_d   = load;         store_d  = store;
          wen0_d   = wen0 & ~store & (~load | al0);
          wen1_d   = wen1 & ~store & (~load | al1);
          wdata0_d = aluresult0;   wdata1_d = aluresult1;
          addr0_d  = aluresult0;   addr1_d  = aluresult1;
          sdata0_d = storedata0;   sdata1_d = storedata1;
          woff0_d  = woffset0;     woff1_d  = woffset1;
          eew_d    = eew;          vd_d     = vd;
          cfg_d    = config_type;  sbw_d    = single_bit_write;
          vtype_d  = vtype;        vl_d     = vl;       vstart_d = vstart;
          mis_d    = mem_op & ((wen0 & ~al0) | (wen1 & ~al1));
          need1_d  = need1;
          state_d  = need0 ? ACC0 : (need1 ? ACC1 : DONE);
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;  load_q <= 1'b0;   store_q <= 1'b0;
      wen0_q <= 1'b0;   wen1_q <= 1'b0;   wdata0_q <= '0;   wdata1_q <= '0;
      addr0_q <= '0;    addr1_q <= '0;    sdata0_q <= '0;   sdata1_q <= '0;
      woff0_q <= '0;    woff1_q <= '0;    eew_q <= '0;      vd_q <= '0;
      cfg_q <= 1'b0;    sbw_q <= 1'b0;    vtype_q <= '0;    vl_q <= '0;
      vstart_q <= '0;   mis_q <= 1'b0;    need1_q <= 1'b0;
    end else begin
      state_q <= state_d;  load_q <= load_d;    store_q <= store_d;
      wen0_q <= wen0_d;    wen1_q <= wen1_d;    wdata0_q <= wdata0_d;  wdata1_q <= wdata1_d;
      addr0_q <= addr0_d;  addr1_q <= addr1_d;  sdata0_q <= sdata0_d;  sdata1_q <= sdata1_d;
      woff0_q <= woff0_d;  woff1_q <= woff1_d;  eew_q <= eew_d;        vd_q <= vd_d;
      cfg_q <= cfg_d;      sbw_q <= sbw_d;      vtype_q <= vtype_d;    vl_q <= vl_d;
      vstart_q <= vstart_d; mis_q <= mis_d;     need1_q <= need1_d;
    end
  end

  // Writeback fields hold the last bundle; only out_valid/misaligned are gated.
  assign out_valid            = (state_q == DONE);
  assign misaligned           = out_valid & mis_q;
  assign out_wen0             = wen0_q;
  assign out_wen1             = wen1_q;
  assign out_wdata0           = wdata0_q;
  assign out_wdata1           = wdata1_q;
  assign out_woffset0         = woff0_q;
  assign out_woffset1         = woff1_q;
  assign out_vd               = vd_q;
  assign out_config_type      = cfg_q;
  assign out_single_bit_write = sbw_q;
  assign out_vtype            = vtype_q;
  assign out_vl               = vl_q;
  assign out_vstart           = vstart_q;
endmodule

// File: tb/tb_rv32v_memory_stage.sv
// Directed bench for rv32v_memory_stage: ALU, load, store, misaligned, reset, config.
module tb_rv32v_memory_stage;
  localparam int OFFSET_W = 7;

  logic CLK = 1'b0, RST = 1'b1;
  logic in_valid = 0, in_ready, load = 0, store = 0, wen0 = 0, wen1 = 0;
  logic [31:0] aluresult0 = 0, aluresult1 = 0, storedata0 = 0, storedata1 = 0;
  logic [OFFSET_W-1:0] woffset0 = 0, woffset1 = 0;
  logic [1:0] eew = 0;
  logic [4:0] vd = 0;
  logic config_type = 0, single_bit_write = 0;
  logic [7:0] vtype = 0;
  logic [31:0] vl = 0, vstart = 0;
  logic dren, dwen, dbusy = 0;
  logic [31:0] daddr, dstore, dload = 0;
  logic [3:0] dbyte_en;
  logic out_valid, out_wen0, out_wen1, out_config_type, out_single_bit_write, misaligned;
  logic [31:0] out_wdata0, out_wdata1, out_vl, out_vstart;
  logic [OFFSET_W-1:0] out_woffset0, out_woffset1;
  logic [4:0] out_vd;
  logic [7:0] out_vtype;

  int vectors = 0, miscompares = 0;

  always #5 CLK = ~CLK;

  rv32v_memory_stage #(.OFFSET_W(OFFSET_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .load(load), .store(store), .wen0(wen0), .wen1(wen1),
    .aluresult0(aluresult0), .aluresult1(aluresult1),
    .storedata0(storedata0), .storedata1(storedata1),
    .woffset0(woffset0), .woffset1(woffset1), .eew(eew), .vd(vd),
    .config_type(config_type), .single_bit_write(single_bit_write),
    .vtype(vtype), .vl(vl), .vstart(vstart),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dbyte_en(dbyte_en),
    .dbusy(dbusy), .dload(dload),
    .out_valid(out_valid), .out_wen0(out_wen0), .out_wen1(out_wen1),
    .out_wdata0(out_wdata0), .out_wdata1(out_wdata1),
    .out_woffset0(out_woffset0), .out_woffset1(out_woffset1), .out_vd(out_vd),
    .out_config_type(out_config_type), .out_single_bit_write(out_single_bit_write),
    .out_vtype(out_vtype), .out_vl(out_vl), .out_vstart(out_vstart),
    .misaligned(misaligned)
  );

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dren", dren, 0);
    chk("rst_dwen", dwen, 0);
    chk("rst_byte_en", dbyte_en, 0);
    chk("rst_wdata0", out_wdata0, 0);
    chk("rst_misaligned", misaligned, 0);
    RST = 0;
    tick();

    // ALU bundles back-to-back
    in_valid = 1; wen0 = 1; wen1 = 1; aluresult0 = 32'h11; aluresult1 = 32'h22;
    tick();
    chk("alu1_valid", out_valid, 1);
    chk("alu1_wdata0", out_wdata0, 32'h11);
    chk("alu1_wdata1", out_wdata1, 32'h22);
    chk("alu1_in_ready", in_ready, 1);
    aluresult0 = 32'h33; aluresult1 = 32'h44;
    tick();
    chk("alu2_valid", out_valid, 1);
    chk("alu2_wdata0", out_wdata0, 32'h33);
    chk("alu2_wdata1", out_wdata1, 32'h44);
    chk("alu2_dren", dren, 0);
    in_valid = 0;
    tick();
    chk("alu_idle_valid", out_valid, 0);

    // 8b load, both lanes
    in_valid = 1; load = 1; eew = 0; aluresult0 = 32'h101; aluresult1 = 32'h103;
    dload = 32'hAABBCCDD;
    tick(); in_valid = 0;
    chk("ld8_acc0_dren", dren, 1);
    chk("ld8_acc0_be", dbyte_en, 4'b0010);
    chk("ld8_acc0_addr", daddr, 32'h100);
    chk("ld8_acc0_ready", in_ready, 0);
    tick();
    chk("ld8_acc1_be", dbyte_en, 4'b1000);
    chk("ld8_acc1_valid", out_valid, 0);
    tick();
    chk("ld8_valid", out_valid, 1);
    chk("ld8_wdata0", out_wdata0, 32'hCC);
    chk("ld8_wdata1", out_wdata1, 32'hAA);
    chk("ld8_wen", {out_wen1, out_wen0}, 2'b11);
    chk("ld8_done_dren", dren, 0);
    tick();

    // 16b store, lane1 only, two wait states
    in_valid = 1; load = 0; store = 1; eew = 1; wen0 = 0; wen1 = 1;
    aluresult1 = 32'h202; storedata1 = 32'h1234; dbusy = 1;
    tick(); in_valid = 0;
    chk("st16_c1_dwen", dwen, 1);
    chk("st16_c1_addr", daddr, 32'h200);
    chk("st16_c1_be", dbyte_en, 4'b1100);
    chk("st16_c1_data", dstore, 32'h12341234);
    chk("st16_c1_dren", dren, 0);
    tick();
    chk("st16_c2_dwen", dwen, 1);
    chk("st16_c2_data", dstore, 32'h12341234);
    tick();
    chk("st16_c3_dwen", dwen, 1);
    chk("st16_c3_valid", out_valid, 0);
    dbusy = 0;
    tick();
    chk("st16_valid", out_valid, 1);
    chk("st16_wen1", out_wen1, 0);
    chk("st16_done_dwen", dwen, 0);
    tick();

    // Misaligned 32b load on lane0
    in_valid = 1; store = 0; load = 1; eew = 2; wen0 = 1; wen1 = 1;
    aluresult0 = 32'h301; aluresult1 = 32'h304; dload = 32'hCAFEBABE;
    tick(); in_valid = 0;
    chk("mis_dren", dren, 1);
    chk("mis_addr", daddr, 32'h304);
    chk("mis_be", dbyte_en, 4'b1111);
    tick();
    chk("mis_valid", out_valid, 1);
    chk("mis_wen0", out_wen0, 0);
    chk("mis_wen1", out_wen1, 1);
    chk("mis_wdata1", out_wdata1, 32'hCAFEBABE);
    chk("mis_flag", misaligned, 1);
    tick();
    chk("mis_flag_clear", misaligned, 0);

    // Reset while lane1 access is stalled
    in_valid = 1; wen0 = 0; wen1 = 1; aluresult1 = 32'h400; dbusy = 1;
    tick(); in_valid = 0;
    chk("rstacc_dren_before", dren, 1);
    RST = 1;
    tick();
    chk("rstacc_dren", dren, 0);
    chk("rstacc_valid", out_valid, 0);
    chk("rstacc_ready", in_ready, 1);
    RST = 0; dbusy = 0;
    tick();
    chk("rstacc_no_valid", out_valid, 0);

    // Config bundle passthrough
    in_valid = 1; load = 0; wen0 = 0; wen1 = 0; config_type = 1; single_bit_write = 1;
    vl = 8; vtype = 8'h10; vstart = 3; vd = 5'd7; woffset0 = 7'd5; woffset1 = 7'd6;
    tick(); in_valid = 0;
    chk("cfg_valid", out_valid, 1);
    chk("cfg_type", out_config_type, 1);
    chk("cfg_sbw", out_single_bit_write, 1);
    chk("cfg_vl", out_vl, 8);
    chk("cfg_vtype", out_vtype, 8'h10);
    chk("cfg_vstart", out_vstart, 3);
    chk("cfg_vd", out_vd, 7);
    chk("cfg_woff", {out_woffset1, out_woffset0}, {7'd6, 7'd5});
    chk("cfg_req", {dren, dwen}, 2'b00);
    tick();
    chk("cfg_after_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
